// File: rtl/sram_fifo_pkg.sv
// Shared sizing and types for the SRAM-backed streaming FIFO.
// Widths are tied to the 23-bit x 32-word 1W1R macro.
package sram_fifo_pkg;

  localparam int DATA_WIDTH = 23;
  localparam int ADDR_WIDTH = 5;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [ADDR_WIDTH:0]   cnt_t;
  typedef logic [ADDR_WIDTH+1:0] lvl_t;

endpackage

// File: rtl/sram_fifo_outbuf.sv
// 2-entry in-order skid buffer holding prefetched SRAM read data; head is visible next cycle.
// The caller must not push when full without a simultaneous pop.
module sram_fifo_outbuf
  import sram_fifo_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            ob_cnt
);

  word_t ent0;
  word_t ent1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ob_cnt <= 2'd0;
      ent0   <= '0;
      ent1   <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (ob_cnt == 2'd0) ent0 <= push_data;
          else                ent1 <= push_data;
          ob_cnt <= ob_cnt + 2'd1;
        end
        2'b01: begin
          ent0   <= ent1;
          ob_cnt <= ob_cnt - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever remains.
          if (ob_cnt == 2'd1) begin
            ent0 <= push_data;
          end else begin
            ent0 <= ent1;
            ent1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (ob_cnt != 2'd0);
  assign out_data  = ent0;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Streaming valid/ready FIFO over an external 1W1R SRAM macro; empty-to-out latency 3 cycles.
// in_ready drops only when the SRAM is full; reads are issued only while the output buffer has room.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  addr_t      wr_ptr;
  addr_t      rd_ptr;
  cnt_t       sram_cnt;
  cnt_t       sram_cnt_next;
  logic       inflight;
  logic [1:0] ob_cnt;
  logic [2:0] ob_occ;
  logic       in_fire;
  logic       out_fire;
  logic       rd_issue;

  assign in_ready = rst_n & (sram_cnt != cnt_t'(DEPTH));
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Buffer occupancy at the end of this cycle, counting the read already in flight.
  assign ob_occ   = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, out_fire};
  assign rd_issue = rst_n & (sram_cnt != '0) & (ob_occ < 3'd2);

  assign sram_cnt_next = sram_cnt + cnt_t'(in_fire) - cnt_t'(rd_issue);

  assign sram_csb0  = ~in_fire;
  assign sram_addr0 = wr_ptr;
  assign sram_din0  = in_data;
  assign sram_csb1  = ~rd_issue;
  assign sram_addr1 = rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      sram_cnt <= '0;
      inflight <= 1'b0;
      count    <= '0;
    end else begin
      wr_ptr   <= wr_ptr + addr_t'(in_fire);
      rd_ptr   <= rd_ptr + addr_t'(rd_issue);
      sram_cnt <= sram_cnt_next;
      inflight <= rd_issue;
      count    <= lvl_t'(sram_cnt_next) + lvl_t'(rd_issue) + lvl_t'(ob_occ);
    end
  end

  // Macro read data is only valid in the cycle after an issue.
  sram_fifo_outbuf u_outbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (sram_dout1),
    .pop       (out_fire),
    .out_valid (out_valid),
    .out_data  (out_data),
    .ob_cnt    (ob_cnt)
  );

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural 1W1R macro and an in-order scoreboard.
module tb_sram_fifo_ctrl;

  logic        clk0 = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [22:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [22:0] out_data;
  logic [6:0]  count;
  logic        sram_csb0;
  logic [4:0]  sram_addr0;
  logic [22:0] sram_din0;
  logic        sram_csb1;
  logic [4:0]  sram_addr1;
  logic [22:0] sram_dout1 = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int collisions = 0;

  always #5 clk0 = ~clk0;

  sram_fifo_ctrl dut (
    .clk        (clk0),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .count      (count),
    .sram_csb0  (sram_csb0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_csb1  (sram_csb1),
    .sram_addr1 (sram_addr1),
    .sram_dout1 (sram_dout1)
  );

  // Macro model: ports registered at posedge, write then read at the following negedge.
  logic [22:0] mem [32];
  logic        csb0_q = 1'b1;
  logic        csb1_q = 1'b1;
  logic [4:0]  a0_q = '0;
  logic [4:0]  a1_q = '0;
  logic [22:0] d0_q = '0;

  always @(posedge clk0) begin
    if (!sram_csb0 && !sram_csb1 && sram_addr0 == sram_addr1) begin
      collisions++;
      $display("warning: simultaneous access to address %0d", sram_addr0);
    end
    csb0_q <= sram_csb0;
    csb1_q <= sram_csb1;
    a0_q   <= sram_addr0;
    a1_q   <= sram_addr1;
    d0_q   <= sram_din0;
  end

  always @(negedge clk0) begin
    if (!csb0_q) mem[a0_q] = d0_q;
    if (!csb1_q) sram_dout1 = mem[a1_q];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every accepted word must come out once, in order; reset discards all.
  logic [22:0] exp_q [$];
  always @(negedge clk0) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          chk("sb_data", 32'(out_data), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic drain(input string tag);
    bit done = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk0);
      if (count == 7'd0 && !out_valid) done = 1;
      else tick();
    end
    chk({tag, "_drained"}, 32'(done), 32'd1);
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    int lat, acc, drops, outs, bad, got;
    bit found;
    logic [22:0] nxt;

    // Reset state
    tick(); tick();
    @(negedge clk0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_csb0", 32'(sram_csb0), 32'd1);
    chk("rst_csb1", 32'(sram_csb1), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Single word latency
    in_valid = 1'b1; in_data = 23'h12345; out_ready = 1'b1;
    @(negedge clk0);
    chk("t1_csb0", 32'(sram_csb0), 32'd0);
    chk("t1_addr0", 32'(sram_addr0), 32'd0);
    chk("t1_din0", 32'(sram_din0), 32'h12345);
    tick();
    in_valid = 1'b0;
    lat = 0; found = 0;
    for (int i = 1; i <= 8 && !found; i++) begin
      @(negedge clk0);
      if (i == 1) begin
        chk("t1_csb1", 32'(sram_csb1), 32'd0);
        chk("t1_count", 32'(count), 32'd1);
      end
      if (out_valid) begin found = 1; lat = i; end
      else tick();
    end
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_data", 32'(out_data), 32'h12345);
    tick();
    @(negedge clk0);
    chk("t1_count_empty", 32'(count), 32'd0);
    chk("t1_out_valid_off", 32'(out_valid), 32'd0);
    tick();

    // Streaming at full rate
    out_ready = 1'b1; nxt = 23'd1; drops = 0; outs = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_data = nxt;
      @(negedge clk0);
      if (!in_ready) drops++;
      if (in_ready) nxt = nxt + 23'd1;
      if (out_valid) outs++;
      tick();
    end
    in_valid = 1'b0;
    chk("t2_in_ready_drops", 32'(drops), 32'd0);
    chk("t2_outputs", 32'(outs), 32'd97);
    drain("t2");

    // Fill with no consumer
    out_ready = 1'b0; acc = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; in_data = 23'h100 + 23'(i);
      @(negedge clk0);
      if (in_ready) acc++;
      else if (!sram_csb0) bad++;
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk0);
    chk("t3_accepted", 32'(acc), 32'd34);
    chk("t3_count", 32'(count), 32'd34);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    chk("t3_csb0_when_full", 32'(bad), 32'd0);
    chk("t3_out_valid", 32'(out_valid), 32'd1);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    got = 0;
    for (int k = 0; k < 2 && got == 0; k++) begin
      @(negedge clk0);
      if (in_ready) got = 1;
      else tick();
    end
    chk("t3_reraise", 32'(got), 32'd1);
    drain("t3");

    // Wrap with random consumer
    acc = 0;
    for (int i = 0; i < 2000 && acc < 64; i++) begin
      in_valid = 1'b1; in_data = 23'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk0);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    chk("t4_accepted", 32'(acc), 32'd64);
    drain("t4");

    // Reset with words held and a read in flight
    out_ready = 1'b0; acc = 0;
    for (int i = 0; i < 100 && acc < 11; i++) begin
      in_valid = 1'b1; in_data = 23'h200 + 23'(i);
      @(negedge clk0);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    @(negedge clk0);
    chk("t5_count_before", 32'(count), 32'd11);
    tick();
    out_ready = 1'b1;
    @(negedge clk0);
    chk("t5_pop_issues_read", 32'(sram_csb1), 32'd0);
    tick();
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk0);
    chk("t5_held", 32'(count), 32'd10);
    chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
    chk("t5_rst_csb0", 32'(sram_csb0), 32'd1);
    chk("t5_rst_csb1", 32'(sram_csb1), 32'd1);
    tick();
    rst_n = 1'b1;
    @(negedge clk0);
    chk("t5_count_cleared", 32'(count), 32'd0);
    chk("t5_out_valid_cleared", 32'(out_valid), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = 23'h7FFFFF; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk0);
      if (out_valid) found = 1;
      else tick();
    end
    chk("t5_first_seen", 32'(found), 32'd1);
    chk("t5_first_data", 32'(out_data), 32'h7FFFFF);
    tick();
    drain("t5");

    // Idle with a ready consumer
    out_ready = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk0);
      chk("t6_csb1_idle", 32'(sram_csb1), 32'd1);
      chk("t6_out_valid_idle", 32'(out_valid), 32'd0);
      tick();
    end

    chk("no_collisions", 32'(collisions), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
